// File: rtl/arb_pkg.sv
// Shared encodings for the data-RAM arbiter: FSM states and port identifiers.
package arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    function automatic logic other_port(input logic p);
        return ~p;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational winner select for the data-RAM arbiter: lock retention,
// single-requester pass-through, otherwise round-robin.
module rr_pick
    import arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       a_req,
    input  logic       b_req,
    input  logic       rr_ptr,
    input  logic       locked,
    input  logic       owner,
    input  logic [3:0] burst_cnt,
    output logic       winner,
    output logic       burst_expired
);

    localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

    logic owner_req;
    logic keep_owner;
    logic rr_eff;

    assign owner_req     = (owner == PORT_B) ? b_req : a_req;
    assign keep_owner    = locked && owner_req && (burst_cnt < BURST_MAX);
    assign burst_expired = locked && owner_req && (burst_cnt >= BURST_MAX);

    // An exhausted owner hands the tie-break to the waiting port.
    assign rr_eff = burst_expired ? other_port(owner) : rr_ptr;

    always_comb begin
        winner = rr_eff;
        if (keep_owner)
            winner = owner;
        else if (a_req && !b_req)
            winner = PORT_A;
        else if (b_req && !a_req)
            winner = PORT_B;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM; each transfer takes a
// fixed IDLE -> ACCESS -> RESP sequence with registered outputs.
//
// state     | meaning
// ST_IDLE   | sample requests, pick winner, launch RAM access
// ST_ACCESS | RAM write/read in progress, capture read data, raise ack
// ST_RESP   | ack high for the owner, requests ignored
module dmem_arbiter
    import arb_pkg::*;
#(
    parameter int IDX_W     = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [IDX_W-1:0]  a_index,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [IDX_W-1:0]  b_index,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_ack,
    output logic [DATA_W-1:0] b_rdata,
    output logic              mem_wr_en,
    output logic [IDX_W-1:0]  mem_index,
    output logic [DATA_W-1:0] mem_entry,
    input  logic [DATA_W-1:0] mem_entry_out,
    output logic [31:0]       a_grant_cnt,
    output logic [31:0]       b_grant_cnt
);

    state_t      state;
    logic        rr_ptr;
    logic        owner;
    logic        locked;
    logic [3:0]  burst_cnt;

    logic              winner;
    logic              burst_expired;
    logic              win_we;
    logic              win_lock;
    logic [IDX_W-1:0]  win_index;
    logic [DATA_W-1:0] win_wdata;
    logic              locked_eff;
    logic              rr_eff;

    rr_pick #(.MAX_BURST(MAX_BURST)) u_pick (
        .a_req         (a_req),
        .b_req         (b_req),
        .rr_ptr        (rr_ptr),
        .locked        (locked),
        .owner         (owner),
        .burst_cnt     (burst_cnt),
        .winner        (winner),
        .burst_expired (burst_expired)
    );

    assign win_we     = (winner == PORT_B) ? b_we    : a_we;
    assign win_lock   = (winner == PORT_B) ? b_lock  : a_lock;
    assign win_index  = (winner == PORT_B) ? b_index : a_index;
    assign win_wdata  = (winner == PORT_B) ? b_wdata : a_wdata;

    // Expiry ends the current burst before the winner's own lock is applied.
    assign locked_eff = locked && !burst_expired;
    assign rr_eff     = burst_expired ? other_port(owner) : rr_ptr;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state       <= ST_IDLE;
            rr_ptr      <= PORT_A;
            owner       <= PORT_A;
            locked      <= 1'b0;
            burst_cnt   <= 4'd0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_index   <= '0;
            mem_entry   <= '0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            a_grant_cnt <= 32'd0;
            b_grant_cnt <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (a_req || b_req) begin
                        owner     <= winner;
                        mem_index <= win_index;
                        mem_entry <= win_wdata;
                        mem_wr_en <= win_we;
                        if (winner == PORT_B)
                            b_grant_cnt <= b_grant_cnt + 32'd1;
                        else
                            a_grant_cnt <= a_grant_cnt + 32'd1;
                        if (win_lock) begin
                            burst_cnt <= (winner == owner && locked_eff) ? burst_cnt + 4'd1 : 4'd1;
                            locked    <= 1'b1;
                            rr_ptr    <= rr_eff;
                        end else begin
                            burst_cnt <= 4'd0;
                            locked    <= 1'b0;
                            rr_ptr    <= other_port(winner);
                        end
                        state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_wr_en <= 1'b0;
                    if (owner == PORT_B) begin
                        b_ack <= 1'b1;
                        if (!mem_wr_en)
                            b_rdata <= mem_entry_out;
                    end else begin
                        a_ack <= 1'b1;
                        if (!mem_wr_en)
                            a_rdata <= mem_entry_out;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    a_ack <= 1'b0;
                    b_ack <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
